// File: rtl/pcmd_sched.sv
// pcmd_sched: shared-bus command scheduler for the PE array.
// Arbitrates NREQ (address, opcode) requesters and serialises the winner as a
// 17-bit frame (start 0, address LSB first, command LSB first) on tx. After
// each frame tx is held idle high for a guard window: GUARD_LONG after
// OUT_RES, GUARD_SHORT after any other opcode.
// Build option: define PCMD_FIXED_PRI_EN for fixed priority (lowest index
// wins, no rr pointer); the default build is round-robin.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | line idle high, arbitrate and capture a request
// S_START | start bit (0) on the line
// S_ADDR  | 8 address bits, LSB first
// S_CMD   | 8 command bits, LSB first
// S_GUARD | line idle high while the addressed PE executes

module pcmd_sched #(
  parameter int NREQ        = 4,
  parameter int GUARD_SHORT = 34,
  parameter int GUARD_LONG  = 130
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] addr_flat,
  input  logic [3*NREQ-1:0] op_flat,
  output logic [NREQ-1:0]   gnt,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = $clog2(GUARD_LONG + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ADDR  = 3'd2,
    S_CMD   = 3'd3,
    S_GUARD = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [16:0]   r_sr, w_sr_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [GW-1:0] r_guard, w_guard_nxt;
  logic          r_long, w_long_nxt;
  logic          r_tx, w_tx_nxt;
  logic          r_busy, r_done;
  logic          w_found;
  logic [IW-1:0] w_win;
  logic [7:0]    w_addr;
  logic [2:0]    w_op;

`ifndef PCMD_FIXED_PRI_EN
  logic [IW-1:0]     r_rr, w_rr_nxt;
  logic [2*NREQ-1:0] w_req_dbl;
  logic [NREQ-1:0]   w_req_rot;
  logic [IW:0]       w_idx;

  // Round-robin search: rotate req so bit 0 is the pointer position.
  always_comb begin
    w_req_dbl = {req, req};
    w_req_rot = w_req_dbl[r_rr +: NREQ];
    w_found   = 1'b0;
    w_win     = '0;
    w_idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && w_req_rot[i]) begin
        w_found = 1'b1;
        w_idx   = {1'b0, r_rr} + (IW+1)'(i);
        if (w_idx >= (IW+1)'(NREQ)) w_idx = w_idx - (IW+1)'(NREQ);
        w_win   = w_idx[IW-1:0];
      end
    end
    w_rr_nxt = r_rr;
    if (r_state == S_IDLE && w_found)
      w_rr_nxt = (w_win == IW'(NREQ-1)) ? '0 : w_win + 1'b1;
  end

  // Pointer advances past the winner on every capture.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) r_rr <= '0;
    else       r_rr <= w_rr_nxt;
  end
`else
  // Fixed priority: descending scan so the lowest active index is kept.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req[i]) begin
        w_found = 1'b1;
        w_win   = IW'(i);
      end
    end
  end
`endif

  // Winner's address/opcode mux and the grant decode (IDLE only).
  always_comb begin
    w_addr = '0;
    w_op   = '0;
    gnt    = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_win == IW'(j)) begin
        w_addr = addr_flat[8*j +: 8];
        w_op   = op_flat[3*j +: 3];
      end
      gnt[j] = (r_state == S_IDLE) && w_found && (w_win == IW'(j));
    end
  end

  // Next state; w_tx_nxt is the bit the line shows in the next cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_bit_nxt   = r_bit;
    w_guard_nxt = r_guard;
    w_long_nxt  = r_long;
    w_tx_nxt    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_sr_nxt    = {4'b0000, w_op, 1'b0, w_addr, 1'b0};
          w_long_nxt  = (w_op == 3'd2);
          w_tx_nxt    = 1'b0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tx_nxt    = r_sr[1];
        w_sr_nxt    = r_sr >> 1;
        w_bit_nxt   = 3'd7;
        w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        w_tx_nxt  = r_sr[1];
        w_sr_nxt  = r_sr >> 1;
        w_bit_nxt = r_bit - 3'd1;
        if (r_bit == 3'd0) begin
          w_bit_nxt   = 3'd7;
          w_state_nxt = S_CMD;
        end
      end
      S_CMD: begin
        w_tx_nxt  = r_sr[1];
        w_sr_nxt  = r_sr >> 1;
        w_bit_nxt = r_bit - 3'd1;
        if (r_bit == 3'd0) begin
          w_tx_nxt    = 1'b1;
          w_guard_nxt = r_long ? GW'(GUARD_LONG) : GW'(GUARD_SHORT);
          w_state_nxt = S_GUARD;
        end
      end
      S_GUARD: begin
        w_guard_nxt = r_guard - GW'(1);
        if (r_guard == GW'(1)) begin
          w_guard_nxt = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  // State and datapath registers; done/busy are looked ahead by one cycle.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_bit   <= '0;
      r_guard <= '0;
      r_long  <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_bit   <= w_bit_nxt;
      r_guard <= w_guard_nxt;
      r_long  <= w_long_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_GUARD) && (w_guard_nxt == GW'(1));
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: doc/pcmd_sched.md
Name: pcmd_sched

Overview:
- Shared-bus command scheduler for the processing-element array.
- Accepts (address, opcode) command requests from N requesters and arbitrates between them.
- Serialises the winning command onto the single broadcast serial line that feeds every PE controller.
- Holds the line idle for an opcode-dependent guard window so the addressed PE completes its execute phase before the next frame starts.

Parameters:
- NREQ, 4, number of requesters (2..8).
- GUARD_SHORT, 34, idle-high cycles after any frame except OUT_RES.
- GUARD_LONG, 130, idle-high cycles after an OUT_RES frame.

Ports:
- clk  in  1  system clock.
- nRst  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request level; held until granted.
- addr_flat  in  8*NREQ  requester i target PE address at [8i+7:8i].
- op_flat  in  3*NREQ  requester i opcode at [3i+2:3i] (0 OUT_DATA1, 1 OUT_DATA2, 2 OUT_RES, 3 LOAD, 4 LOAD_RES, 5 MUL, 6 MUL_ADD, 7 NO_OP).
- gnt  out  NREQ  one-cycle one-hot pulse when a request is captured.
- tx  out  1  serial command line to all PEs; idle high.
- busy  out  1  high from capture until guard expiry.
- done  out  1  one-cycle pulse on the last guard cycle.

Behaviour:
- Reset values: tx=1, gnt=0, busy=0, done=0, state=IDLE, rr pointer=0, shift register=0, counters=0.
- Reset asserted mid-frame aborts immediately; tx returns high asynchronously.
- Frame: 17 bits, one per clk.
  - 1 start bit (0).
  - 8 address bits, LSB first.
  - 8 command bits, LSB first: cmd[3:1]=opcode, cmd[0]=0, cmd[7:4]=0.
- States:
  - IDLE: tx=1. If any req, the arbiter picks winner w. gnt[w]=1 for that cycle, addr/op of w latched into a 17-bit shift register, busy<=1, go to START.
  - START: tx=0 for 1 cycle, bit counter<=7, go to ADDR.
  - ADDR: tx=current address bit, shift each cycle. At counter 0, reload 7 and go to CMD.
  - CMD: tx=current command bit. At counter 0, load guard counter (GUARD_LONG if latched op==2, else GUARD_SHORT) and go to GUARD.
  - GUARD: tx=1, decrement each cycle. On the cycle the counter reads 1: done=1, busy<=0, go to IDLE.
- Latency:
  - Request seen in IDLE at cycle t: gnt at t, start bit at t+1, last command bit at t+17.
  - First IDLE cycle is t+18+GUARD.
  - A back-to-back request is granted in that first IDLE cycle.
- Arbitration (default): round-robin. Search starts at rr pointer; after grant to w, pointer<=(w+1) mod NREQ. Pointer wraps NREQ-1 -> 0.
- gnt is only issued in IDLE. Requests changing during a frame have no effect on the frame in flight.
- Requester must drop req the cycle after gnt, or it is treated as a new request.
- NO_OP (7) is transmitted normally, with a short guard.
- Unknown state -> IDLE with tx=1.
- All outputs registered except gnt, which is decoded from the registered state plus req.

Optional Feature:
- Macro PCMD_FIXED_PRI_EN.
- Defined: fixed priority, lowest index wins; rr pointer removed.
- Undefined: round-robin as above.
- Frame format and timing are identical in both builds.

Test Plan:
1. Reset then idle, no req for 50 cycles -> tx=1, busy=0, gnt=0 throughout. Assert nRst low mid-ADDR -> tx=1, state IDLE same cycle.
2. req[1]=1, addr=0x5A, op=MUL(5) -> gnt=4'b0010 one cycle, tx sequence 0, 0,1,0,1,1,0,1,0, 0,1,0,1,0,0,0,0. Then 34 high cycles, done pulse on the 34th, busy falls.
3. req[2], op=OUT_RES(2), addr=0x03 -> guard 130 cycles measured from the cycle after the last command bit to done; cmd bits 0,0,1,0,0,0,0,0.
4. req=4'b1111 held, releasing each after its gnt -> grant order 0,1,2,3; 5th request from req[0] granted next (wrap). With PCMD_FIXED_PRI_EN and req[0] reasserted each time -> req[0] wins repeatedly, others starve.
5. req[3] asserted during GUARD of a prior frame -> no gnt until IDLE. Gnt appears exactly 18+GUARD_SHORT cycles after the previous capture.
6. Loopback: tx into one PE command decoder with address 0x5A; send LOAD to 0x5A and to 0x11 -> only the 0x5A decoder presents opcode 3. Bus is idle high at the start of the next frame.
